// File: rtl/uart_device.sv
// Memory-mapped 8N1 UART for a BusControl device slot: TX/RX byte FIFOs,
// serialiser/deserialiser state machines and a pollable status register.
module uart_device #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic [7:0] Bus_In,
    output logic [7:0] Bus_Out,
    output logic       Bus_OE,
    input  logic       Dev_Load_n,
    input  logic       Dev_Assert_n,
    input  logic       Reg_Sel,
    input  logic       Uart_Rx,
    output logic       Uart_Tx,
    output logic       Irq_n
);

    localparam int unsigned DEPTH     = 1 << FIFO_AW;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    tx_state_e tx_state;
    rx_state_e rx_state;

    // ---------------- bus decode ----------------
    logic data_wr, data_rd, status_rd;

    assign data_wr   = !Dev_Load_n && !Reg_Sel;
    assign data_rd   = !Dev_Assert_n && !Reg_Sel;
    assign status_rd = !Dev_Assert_n && Reg_Sel;

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wr_ptr, tx_rd_ptr;
    logic             tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]       tx_head;
    logic [15:0]      tx_cnt;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[FIFO_AW] != tx_rd_ptr[FIFO_AW]) &&
                      (tx_wr_ptr[FIFO_AW-1:0] == tx_rd_ptr[FIFO_AW-1:0]);
    assign tx_head  = tx_mem[tx_rd_ptr[FIFO_AW-1:0]];
    assign tx_push  = data_wr && !tx_full;
    // The serialiser takes a byte from IDLE, or straight out of the last STOP cycle.
    assign tx_pop   = !tx_empty &&
                      ((tx_state == TxIdle) || (tx_state == TxStop && tx_cnt == BIT_LAST));

    always_ff @(posedge Clock_In) begin
        if (tx_push) tx_mem[tx_wr_ptr[FIFO_AW-1:0]] <= Bus_In;
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    logic [2:0] tx_idx;
    logic [7:0] tx_shift;

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            tx_state <= TxIdle;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            Uart_Tx  <= 1'b1;
        end else begin
            case (tx_state)
                TxIdle: begin
                    Uart_Tx <= 1'b1;
                    tx_cnt  <= '0;
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        tx_state <= TxStart;
                    end
                end
                TxStart: begin
                    Uart_Tx <= 1'b0;
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_state <= TxData;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TxData: begin
                    Uart_Tx <= tx_shift[tx_idx];
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        tx_idx <= tx_idx + 3'd1;
                        if (tx_idx == 3'd7) tx_state <= TxStop;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TxStop: begin
                    Uart_Tx <= 1'b1;
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_pop) begin
                            tx_shift <= tx_head;
                            tx_state <= TxStart;
                        end else begin
                            tx_state <= TxIdle;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    // ---------------- RX synchroniser and FSM ----------------
    logic [1:0]  rx_sync;
    logic        rx_bit;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_valid, rx_ferr;

    assign rx_bit = rx_sync[1];

    always_ff @(posedge Clock_In) begin
        if (Reset_In) rx_sync <= 2'b11;
        else          rx_sync <= {rx_sync[0], Uart_Rx};
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            rx_state <= RxIdle;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RxIdle: begin
                    rx_cnt <= '0;
                    if (!rx_bit) rx_state <= RxStart;
                end
                RxStart: begin
                    // Re-check mid start bit; a high here was only a glitch.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_bit ? RxIdle : RxData;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RxData: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_bit, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7) rx_state <= RxStop;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RxStop: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RxIdle;
                        rx_valid <= rx_bit;
                        rx_ferr  <= !rx_bit;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_AW:0] rx_wr_ptr, rx_rd_ptr;
    logic             rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0]       rx_head;

    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[FIFO_AW] != rx_rd_ptr[FIFO_AW]) &&
                      (rx_wr_ptr[FIFO_AW-1:0] == rx_rd_ptr[FIFO_AW-1:0]);
    assign rx_head  = rx_mem[rx_rd_ptr[FIFO_AW-1:0]];
    assign rx_pop   = data_rd && !rx_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign rx_push  = rx_valid && (!rx_full || rx_pop);

    always_ff @(posedge Clock_In) begin
        if (rx_push) rx_mem[rx_wr_ptr[FIFO_AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // ---------------- sticky flags and status ----------------
    logic       rxovf, ferr, txovf;
    logic [7:0] status;

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            rxovf <= 1'b0;
            ferr  <= 1'b0;
            txovf <= 1'b0;
        end else begin
            rxovf <= (rxovf && !status_rd) || (rx_valid && rx_full && !rx_pop);
            ferr  <= (ferr && !status_rd) || rx_ferr;
            txovf <= (txovf && !status_rd) || (data_wr && tx_full);
        end
    end

    assign status = {2'b00, txovf, ferr, rxovf,
                     (tx_empty && tx_state == TxIdle), tx_full, !rx_empty};

    always_comb begin
        Bus_Out = 8'h00;
        if (!Dev_Assert_n) begin
            if (Reg_Sel)        Bus_Out = status;
            else if (!rx_empty) Bus_Out = rx_head;
        end
    end

    assign Bus_OE = !Dev_Assert_n;
    assign Irq_n  = rx_empty;

endmodule

// File: tb/tb_uart_device.sv
// Directed bench for uart_device with CLKS_PER_BIT=4: TX framing and latency,
// FIFO overflow, RX reception, framing errors, reset and glitch rejection.
module tb_uart_device;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       load_n = 1'b1;
    logic       assert_n = 1'b1;
    logic       reg_sel = 1'b0;
    logic       rx = 1'b1;
    logic       tx;
    logic       irq_n;

    int n_checks = 0;
    int n_fails  = 0;

    uart_device #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (AW)
    ) dut (
        .Clock_In    (clk),
        .Reset_In    (rst),
        .Bus_In      (bus_in),
        .Bus_Out     (bus_out),
        .Bus_OE      (bus_oe),
        .Dev_Load_n  (load_n),
        .Dev_Assert_n(assert_n),
        .Reg_Sel     (reg_sel),
        .Uart_Rx     (rx),
        .Uart_Tx     (tx),
        .Irq_n       (irq_n)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input logic [7:0] data);
        @(negedge clk);
        load_n  = 1'b0;
        reg_sel = 1'b0;
        bus_in  = data;
        @(negedge clk);
        load_n = 1'b1;
    endtask

    task automatic bus_read(input logic sel, output logic [7:0] data, output logic oe);
        @(negedge clk);
        assert_n = 1'b0;
        reg_sel  = sel;
        #1;
        data = bus_out;
        oe   = bus_oe;
        @(negedge clk);
        assert_n = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] data, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            rx = data[b];
        end
        repeat (CPB) @(negedge clk);
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // Called on the negedge where a start bit first shows; returns on the
    // negedge where the following frame's start bit would first show.
    task automatic capture_frame(output logic [7:0] data, output logic start_bit,
                                 output logic stop_bit);
        @(negedge clk);
        start_bit = tx;
        for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            data[b] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        repeat (CPB - 1) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        logic       oe;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx !== 1'b1) begin
            n_fails++; $display("FAIL reset_tx: got %b expected 1", tx);
        end
        n_checks++;
        if (bus_oe !== 1'b0) begin
            n_fails++; $display("FAIL reset_oe: got %b expected 0", bus_oe);
        end
        n_checks++;
        if (bus_out !== 8'h00) begin
            n_fails++; $display("FAIL reset_bus_out: got %h expected 00", bus_out);
        end
        n_checks++;
        if (irq_n !== 1'b1) begin
            n_fails++; $display("FAIL reset_irq: got %b expected 1", irq_n);
        end
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h04) begin
            n_fails++; $display("FAIL reset_status: got %h expected 04", d);
        end
        n_checks++;
        if (oe !== 1'b1) begin
            n_fails++; $display("FAIL read_oe: got %b expected 1", oe);
        end
    endtask

    task automatic test_tx_single();
        logic [7:0] d;
        logic       oe, sb, pb;
        bus_write(8'hA5);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin
            n_fails++; $display("FAIL tx_latency_early: got %b expected 1", tx);
        end
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin
            n_fails++; $display("FAIL tx_latency_start: got %b expected 0", tx);
        end
        capture_frame(d, sb, pb);
        n_checks++;
        if (sb !== 1'b0 || pb !== 1'b1) begin
            n_fails++; $display("FAIL tx_single_framing: got start %b stop %b expected 0 1", sb, pb);
        end
        n_checks++;
        if (d !== 8'hA5) begin
            n_fails++; $display("FAIL tx_single_data: got %h expected a5", d);
        end
        repeat (2) @(negedge clk);
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h04) begin
            n_fails++; $display("FAIL tx_single_status: got %h expected 04", d);
        end
    endtask

    // A primer byte keeps the serialiser busy so the 17-write burst meets a
    // FIFO that fills to exactly 16 and drops the last write.
    task automatic test_back_to_back();
        logic [7:0] d;
        logic       oe;
        fork
            begin
                logic [7:0] s;
                logic       o;
                @(negedge clk);
                load_n  = 1'b0;
                reg_sel = 1'b0;
                bus_in  = 8'hFF;
                for (int i = 0; i < 17; i++) begin
                    @(negedge clk);
                    bus_in = i[7:0];
                end
                @(negedge clk);
                load_n = 1'b1;
                bus_read(1'b1, s, o);
                n_checks++;
                if (s !== 8'h22) begin
                    n_fails++; $display("FAIL b2b_status_full: got %h expected 22", s);
                end
                bus_read(1'b1, s, o);
                n_checks++;
                if (s !== 8'h02) begin
                    n_fails++; $display("FAIL b2b_txovf_clear: got %h expected 02", s);
                end
            end
            begin
                logic [7:0] fd, exp;
                logic       sb, pb;
                @(negedge clk);
                repeat (3) @(negedge clk);
                for (int f = 0; f < 17; f++) begin
                    exp = (f == 0) ? 8'hFF : 8'(f - 1);
                    capture_frame(fd, sb, pb);
                    n_checks++;
                    if (fd !== exp || sb !== 1'b0 || pb !== 1'b1) begin
                        n_fails++;
                        $display("FAIL b2b_frame%0d: got %h start %b stop %b expected %h start 0 stop 1",
                                 f, fd, sb, pb, exp);
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h04) begin
            n_fails++; $display("FAIL b2b_status_end: got %h expected 04", d);
        end
    endtask

    task automatic test_rx_basic();
        logic [7:0] d;
        logic       oe;
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (irq_n !== 1'b0) begin
            n_fails++; $display("FAIL rx_irq_set: got %b expected 0", irq_n);
        end
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h05) begin
            n_fails++; $display("FAIL rx_status: got %h expected 05", d);
        end
        bus_read(1'b0, d, oe);
        n_checks++;
        if (d !== 8'h3C || oe !== 1'b1) begin
            n_fails++; $display("FAIL rx_data: got %h oe %b expected 3c oe 1", d, oe);
        end
        n_checks++;
        if (irq_n !== 1'b1) begin
            n_fails++; $display("FAIL rx_irq_clear: got %b expected 1", irq_n);
        end
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h04) begin
            n_fails++; $display("FAIL rx_status_empty: got %h expected 04", d);
        end
        bus_read(1'b0, d, oe);
        n_checks++;
        if (d !== 8'h00) begin
            n_fails++; $display("FAIL rx_empty_read: got %h expected 00", d);
        end
    endtask

    task automatic test_rx_ferr();
        logic [7:0] d;
        logic       oe;
        send_rx(8'h81, 1'b0);
        repeat (8) @(negedge clk);
        n_checks++;
        if (irq_n !== 1'b1) begin
            n_fails++; $display("FAIL ferr_irq: got %b expected 1", irq_n);
        end
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h14) begin
            n_fails++; $display("FAIL ferr_status: got %h expected 14", d);
        end
        send_rx(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h05) begin
            n_fails++; $display("FAIL ferr_recover_status: got %h expected 05", d);
        end
        bus_read(1'b0, d, oe);
        n_checks++;
        if (d !== 8'h55) begin
            n_fails++; $display("FAIL ferr_recover_data: got %h expected 55", d);
        end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] d, exp;
        logic       oe;
        for (int i = 0; i < 17; i++) begin
            send_rx(8'h40 + 8'(i), 1'b1);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (irq_n !== 1'b0) begin
            n_fails++; $display("FAIL rxovf_irq: got %b expected 0", irq_n);
        end
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h0D) begin
            n_fails++; $display("FAIL rxovf_status: got %h expected 0d", d);
        end
        for (int i = 0; i < 16; i++) begin
            exp = 8'h40 + 8'(i);
            bus_read(1'b0, d, oe);
            n_checks++;
            if (d !== exp) begin
                n_fails++; $display("FAIL rxovf_data%0d: got %h expected %h", i, d, exp);
            end
        end
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h04 || irq_n !== 1'b1) begin
            n_fails++; $display("FAIL rxovf_drained: got %h irq %b expected 04 irq 1", d, irq_n);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic       oe, sb, pb;
        bus_write(8'h00);
        repeat (10) @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin
            n_fails++; $display("FAIL midframe_busy: got %b expected 0", tx);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx !== 1'b1) begin
            n_fails++; $display("FAIL midframe_reset_tx: got %b expected 1", tx);
        end
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h04) begin
            n_fails++; $display("FAIL midframe_status: got %h expected 04", d);
        end
        bus_write(8'h5A);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin
            n_fails++; $display("FAIL midframe_restart: got %b expected 0", tx);
        end
        capture_frame(d, sb, pb);
        n_checks++;
        if (d !== 8'h5A || sb !== 1'b0 || pb !== 1'b1) begin
            n_fails++; $display("FAIL midframe_frame: got %h start %b stop %b expected 5a 0 1", d, sb, pb);
        end
        // One-cycle low pulse on the serial input must not start a reception.
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(1'b1, d, oe);
        n_checks++;
        if (d !== 8'h04 || irq_n !== 1'b1) begin
            n_fails++; $display("FAIL glitch: got %h irq %b expected 04 irq 1", d, irq_n);
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_basic();
        test_rx_ferr();
        test_rx_overflow();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
